// File: rtl/serial_adder_subtractor_4.sv
// Bit-serial adder/subtractor. It takes one operand bit per clock, LSB first,
// through a single full adder and one carry flop. Its result matches the
// parallel ripple-carry adder/subtractor:
//   S = {carry_out, sum}, where subtract computes A + ~B + 1.
module serial_adder_subtractor_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CTRL,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   S
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_ctrl;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_b_bit;
  logic             w_sum;
  logic             w_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-adder slice on the current LSBs; B is inverted when subtracting.
  assign w_b_bit    = r_b[0] ^ r_ctrl;
  assign w_sum      = r_a[0] ^ w_b_bit ^ r_carry;
  assign w_carry    = (r_a[0] & w_b_bit) | (r_a[0] & r_carry) | (w_b_bit & r_carry);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // The new sum bit enters at the MSB while older bits move toward the LSB.
  // After WIDTH shifts the register holds the whole sum in bit order.
  assign w_res_next = {w_sum, {(WIDTH-1){1'b0}}} | (r_res >> 1);

  // Control FSM with datapath shift registers and registered outputs.
  // NOTE: the reset branch is inside the clocked block, so the reset is
  // synchronous. All state uses non-blocking assignments, so every register
  // in this block sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ctrl  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_ctrl  <= CTRL;
            r_carry <= CTRL;           // the +1 of two's-complement subtract
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_carry;
          if (w_last) begin
            S       <= {w_carry, w_res_next};
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor_4.sv
// Directed and random bench for the bit-serial adder/subtractor. Inputs are
// driven and outputs sampled on the falling edge of clk.
module tb_serial_adder_subtractor_4;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CTRL;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   S;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_subtractor_4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .CTRL  (CTRL),
    .busy  (busy),
    .done  (done),
    .S     (S)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parallel adder/subtractor reference: A + (B ^ CTRL) + CTRL.
  function automatic logic [WIDTH:0] par_model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
    logic [WIDTH-1:0] bx;
    bx = c ? ~b : b;
    return {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(c);
  endfunction

  // Behavioural reference: carry out on add, no-borrow flag on subtract.
  function automatic logic [WIDTH:0] beh_model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
    logic [WIDTH-1:0] diff;
    diff = a - b;
    if (c) return {(a >= b), diff};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // One operation. It checks four busy cycles, a single-cycle done with S,
  // and then the idle cycle. With noise set, start stays high through SHIFT
  // and DONE, and the operand inputs keep changing.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH:0] exp,
                        input string tag, input bit noise);
    @(negedge clk);
    A = a; B = b; CTRL = c; start = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      start = noise;
      A     = WIDTH'($urandom);
      B     = WIDTH'($urandom);
      CTRL  = 1'($urandom);
      check({tag, " busy"}, {busy, done}, 2'b10);
    end
    @(negedge clk);
    check({tag, " done"}, {busy, done}, 2'b01);
    check({tag, " S"}, S, exp);
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle"}, {busy, done}, 2'b00);
    check({tag, " hold"}, S, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    logic [WIDTH-1:0] ca, cb;
    logic             cc;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; CTRL = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", {busy, done, S}, 7'd0);

    // Idle with start low: nothing moves.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle start0", {busy, done, S}, 7'd0);
    end

    // A start during reset must not begin an operation.
    rst_n = 1'b0; start = 1'b1; A = 4'b1001; B = 4'b0011; CTRL = 1'b1;
    @(negedge clk);
    check("start in reset", {busy, done, S}, 7'd0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("after reset start", {busy, done}, 2'b00);

    // Directed vectors, hand-computed.
    run_op(4'b1001, 4'b0011, 1'b1, 5'b10110, "sub 9-3", 1'b0);
    run_op(4'b1001, 4'b0011, 1'b0, 5'b01100, "add 9+3", 1'b0);
    run_op(4'b0011, 4'b1001, 1'b1, 5'b01010, "sub 3-9", 1'b0);
    run_op(4'b1111, 4'b1111, 1'b0, 5'b11110, "add 15+15", 1'b0);
    run_op(4'b0000, 4'b0000, 1'b1, 5'b10000, "sub 0-0", 1'b0);

    // Start held during SHIFT and DONE is ignored.
    run_op(4'b0110, 4'b0111, 1'b1, 5'b01111, "noise sub 6-7", 1'b1);
    run_op(4'b1000, 4'b1000, 1'b0, 5'b10000, "noise add 8+8", 1'b1);

    // Start held high: an operation is accepted every WIDTH+2 cycles, each
    // using the operands present at its accepting edge.
    @(negedge clk);
    A = 4'd12; B = 4'd5; CTRL = 1'b1; start = 1'b1;
    for (int op = 0; op < 5; op++) begin
      ca = A; cb = B; cc = CTRL;
      @(negedge clk);
      check("cont busy0", {busy, done}, 2'b10);
      A = WIDTH'($urandom); B = WIDTH'($urandom); CTRL = 1'($urandom);
      for (int i = 1; i < WIDTH; i++) begin
        @(negedge clk);
        check("cont busy", {busy, done}, 2'b10);
      end
      @(negedge clk);
      check("cont done", {busy, done}, 2'b01);
      check("cont S", S, par_model(ca, cb, cc));
      @(negedge clk);
      check("cont idle", {busy, done}, 2'b00);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts the operation.
    A = 4'b1001; B = 4'b0011; CTRL = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort shift1", {busy, done}, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort reset", {busy, done, S}, 7'd0);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      check("abort no done", {busy, done, S}, 7'd0);
    end
    run_op(4'b0101, 4'b0110, 1'b0, 5'b01011, "post abort 5+6", 1'b0);

    // Random regression against both reference models.
    for (int n = 0; n < 200; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, par_model(ra, rb, rc), "rand", 1'($urandom));
      check("rand beh", S, beh_model(ra, rb, rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_subtractor_4.md
Name: serial_adder_subtractor_4

Overview:
- Bit-serial, multi-cycle counterpart of the team's 4-bit parallel ripple-carry adder/subtractor.
- Takes the same operands A, B and the same CTRL select, and returns the same (WIDTH+1)-bit S format.
- Processes one bit per clock, LSB first, through a full adder with a single carry flop.
- Used where area matters more than latency; results must match the parallel block bit-for-bit.

Parameters:
- WIDTH, 4, operand width in bits (≥2); S is WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A, unsigned; captured on an accepted start.
- B  input  WIDTH  operand B, unsigned; captured on an accepted start.
- CTRL  input  1  0 = add (A+B), 1 = subtract (A+~B+1); captured on an accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; S is valid in this cycle.
- S  output  WIDTH+1  result; S[WIDTH] = carry out, S[WIDTH-1:0] = sum/difference.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; S=0, busy=0, done=0.
  - operand, carry and counter registers are cleared.
  - Reset has priority over everything, including mid-operation: any operation in progress is aborted and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0, S holds its last value.
  - start=1 at an edge: latch A, B and CTRL into shift registers, load carry=CTRL, counter=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1):
  - Each edge: bit = a[0] ^ (b[0]^ctrl) ^ carry; carry = majority(a[0], b[0]^ctrl, carry).
  - The result bit shifts in at position WIDTH-1 of the result register (the register shifts right); A and B shift right; counter increments.
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th bit): go to DONE and load S = {final carry, result}.
  - start is ignored while in SHIFT.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge returns to IDLE unconditionally; a start seen in DONE is ignored.
  - S is held until the next accepted operation completes.
- Latency:
  - start accepted at edge k → done high in the cycle after edge k+WIDTH.
  - For WIDTH=4: done in the 5th cycle after the accepting edge.
  - Minimum spacing between accepted starts is WIDTH+2 cycles.
- Arithmetic:
  - Add: S = A + B, zero-extended to WIDTH+1 bits; S[WIDTH] is the carry out.
  - Subtract: S[WIDTH-1:0] = (A−B) mod 2^WIDTH; S[WIDTH] = 1 when A ≥ B (no borrow), 0 when A < B.
  - Results are identical to the parallel adder/subtractor for every input combination.
- Inputs A, B and CTRL may change freely after the accepting edge without affecting the operation in progress.
- Counter width is clog2(WIDTH).

Test Plan:
- Reset, then hold start=0 for 10 cycles → S=0, busy=0, done=0 throughout; apply start at an edge with rst_n=0 → no operation begins.
- A=4'b1001, B=4'b0011, CTRL=1, pulse start → busy for 4 cycles, done one cycle later, S=5'b10110. Repeat with CTRL=0 → S=5'b01100.
- Subtract with borrow and edge cases:
  - A=4'b0011, B=4'b1001, CTRL=1 → S=5'b01010.
  - A=4'b1111, B=4'b1111, CTRL=0 → S=5'b11110.
  - A=0, B=0, CTRL=1 → S=5'b10000.
- Protocol robustness:
  - Hold start=1 continuously with changing A/B → operations are accepted only in IDLE, exactly WIDTH+2 cycles apart, and each result matches the operands captured at its accepting edge.
  - start pulsed during SHIFT or DONE has no effect.
- Deassert rst_n during the 2nd SHIFT cycle → next edge: state IDLE, busy=0, S=0, no done pulse; a following operation with A=4'b0101, B=4'b0110, CTRL=0 → S=5'b01011.
- Random regression: ≥200 random A/B/CTRL triples, each compared against the parallel adder/subtractor's S and against a behavioural A±B model → zero mismatches; each done is exactly one cycle wide.
